// File: rtl/jt12_div_prog.sv
// Programmable multi-channel clock-enable divider.
// Each channel divides its source by div_a+1; new ratios take effect on the channel's wrap edge.
module jt12_div_prog #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 5,
    parameter int unsigned CASCADE = 0,
    parameter int unsigned DIV_RST = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_ena,
    input  logic           sync,
    output logic           cfg_ack,
    output logic           cfg_err,
    output logic [NCH-1:0] cfg_pend,
    output logic [NCH-1:0] cen_out
);

    localparam logic [3:0] NchW = 4'(NCH);

    logic [DW-1:0]  cnt_q   [NCH];
    logic [DW-1:0]  div_a_q [NCH];
    logic [DW-1:0]  div_p_q [NCH];
    logic [DW-1:0]  div_n   [NCH];
    logic [NCH-1:0] ena_a_q, ena_p_q, ena_n, pend_q, cen_out_q;
    logic [NCH-1:0] src, tick, wrap, wr, act;
    logic           ack_q, err_q, prev;

    always_comb begin
        src   = '0;
        tick  = '0;
        wrap  = '0;
        wr    = '0;
        act   = '0;
        ena_n = '0;
        prev  = cen;
        for (int k = 0; k < NCH; k++) begin
            div_n[k] = div_p_q[k];
            // In cascade mode each channel is clocked by its upstream neighbour's tick
            src[k]   = (CASCADE != 0) ? prev : cen;
            tick[k]  = src[k] & ena_a_q[k] & (cnt_q[k] == '0);
            wrap[k]  = src[k] & ena_a_q[k] & (cnt_q[k] == div_a_q[k]);
            wr[k]    = cfg_we & (cfg_ch == 3'(k));
            act[k]   = sync | wrap[k] | ~ena_a_q[k];
            ena_n[k] = ena_p_q[k];
            if (wr[k]) begin
                div_n[k] = cfg_div;
                ena_n[k] = cfg_ena;
            end
            prev = tick[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cen_out_q <= '0;
            ena_a_q   <= '1;
            ena_p_q   <= '1;
            pend_q    <= '0;
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k]   <= '0;
                div_a_q[k] <= DW'(DIV_RST);
                div_p_q[k] <= DW'(DIV_RST);
            end
        end else begin
            ack_q     <= cfg_we;
            err_q     <= cfg_we & ({1'b0, cfg_ch} >= NchW);
            cen_out_q <= tick;
            for (int k = 0; k < NCH; k++) begin
                if (sync || wrap[k]) begin
                    cnt_q[k] <= '0;
                end else if (src[k] && ena_a_q[k]) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
                // A write landing on an activation edge bypasses the pending stage
                if (act[k]) begin
                    div_a_q[k] <= div_n[k];
                    div_p_q[k] <= div_n[k];
                    ena_a_q[k] <= ena_n[k];
                    ena_p_q[k] <= ena_n[k];
                    pend_q[k]  <= 1'b0;
                end else if (wr[k]) begin
                    div_p_q[k] <= cfg_div;
                    ena_p_q[k] <= cfg_ena;
                    pend_q[k]  <= 1'b1;
                end
            end
        end
    end

    assign cfg_ack  = ack_q;
    assign cfg_err  = err_q;
    assign cfg_pend = pend_q;
    assign cen_out  = cen_out_q;

endmodule

// File: tb/tb_jt12_div_prog.sv
// Bench for jt12_div_prog: a free-running and a cascaded instance share stimulus and are
// checked every cycle against a behavioural model plus directed pulse-count checks.
module tb_jt12_div_prog;

    logic       clk = 1'b0;
    logic       rst, cen, cfg_we, cfg_ena, sync;
    logic [2:0] cfg_ch;
    logic [4:0] cfg_div;
    logic       a0_ack, a0_err, a1_ack, a1_err;
    logic [3:0] a0_pend, a0_out, a1_pend, a1_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jt12_div_prog #(.NCH(4), .DW(5), .CASCADE(0), .DIV_RST(5)) u_flat (
        .clk(clk), .rst(rst), .cen(cen), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ena(cfg_ena), .sync(sync), .cfg_ack(a0_ack), .cfg_err(a0_err),
        .cfg_pend(a0_pend), .cen_out(a0_out)
    );

    jt12_div_prog #(.NCH(4), .DW(5), .CASCADE(1), .DIV_RST(5)) u_casc (
        .clk(clk), .rst(rst), .cen(cen), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ena(cfg_ena), .sync(sync), .cfg_ack(a1_ack), .cfg_err(a1_err),
        .cfg_pend(a1_pend), .cen_out(a1_out)
    );

    wire [19:0] obs = {a1_out, a1_pend, a1_ack, a1_err, a0_out, a0_pend, a0_ack, a0_err};

    // Reference model: index 0 = independent channels, 1 = cascaded channels
    int       m_cnt [2][4];
    int       m_da  [2][4];
    int       m_dp  [2][4];
    bit [3:0] m_ea [2], m_ep [2], m_pend [2], m_out [2];
    bit       m_ack [2], m_err [2];

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    m_cnt[c][k] = 0;
                    m_da[c][k]  = 5;
                    m_dp[c][k]  = 5;
                end
                m_ea[c] = 4'hF; m_ep[c] = 4'hF; m_pend[c] = 0; m_out[c] = 0;
                m_ack[c] = 0; m_err[c] = 0;
            end else begin
                bit up;
                bit [3:0] tk;
                up = cen;
                for (int k = 0; k < 4; k++) begin
                    bit s, run, at_end, wr;
                    int nd;
                    bit ne;
                    s      = (c == 1) ? up : cen;
                    run    = s && m_ea[c][k];
                    tk[k]  = run && (m_cnt[c][k] == 0);
                    at_end = run && (m_cnt[c][k] == m_da[c][k]);
                    up     = tk[k];
                    wr     = cfg_we && (cfg_ch == 3'(k));
                    nd     = wr ? int'(cfg_div) : m_dp[c][k];
                    ne     = wr ? cfg_ena : m_ep[c][k];
                    if (sync || at_end) m_cnt[c][k] = 0;
                    else if (run)       m_cnt[c][k] = (m_cnt[c][k] + 1) % 32;
                    if (sync || at_end || !m_ea[c][k]) begin
                        m_da[c][k] = nd; m_dp[c][k] = nd;
                        m_ea[c][k] = ne; m_ep[c][k] = ne;
                        m_pend[c][k] = 0;
                    end else if (wr) begin
                        m_dp[c][k] = nd; m_ep[c][k] = ne;
                        m_pend[c][k] = 1;
                    end
                end
                m_out[c] = tk;
                m_ack[c] = cfg_we;
                m_err[c] = cfg_we && (cfg_ch >= 3'd4);
            end
        end
    end

    function automatic logic [19:0] exp_vec();
        return {m_out[1], m_pend[1], m_ack[1], m_err[1], m_out[0], m_pend[0], m_ack[0], m_err[0]};
    endfunction

    task automatic idle_inputs();
        cfg_we = 0; cfg_ch = 0; cfg_div = 0; cfg_ena = 1; sync = 0;
    endtask

    task automatic test_reset();
        rst = 1; cen = 1; cfg_we = 1; cfg_ch = 1; cfg_div = 2; cfg_ena = 1; sync = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== 20'h0 || obs !== exp_vec()) begin
                fails++;
                $display("FAIL reset cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_startup();
        logic [3:0] want;
        idle_inputs();
        rst = 0; cen = 1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            want = (i == 1 || i == 7 || i == 13) ? 4'hF : 4'h0;
            tests++;
            if (a0_out !== want || obs !== exp_vec()) begin
                fails++;
                $display("FAIL startup cyc %0d got %h/%h want %h/%h", i, a0_out, obs, want,
                         exp_vec());
            end
        end
    endtask

    task automatic test_mid_write();
        rst = 1; @(negedge clk); rst = 0; cen = 1;
        repeat (3) @(negedge clk);
        cfg_we = 1; cfg_ch = 1; cfg_div = 2; cfg_ena = 1;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (a0_ack !== 1'b1 || a0_pend[1] !== 1'b1 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL mid_write ack=%b pend=%b got %h want %h", a0_ack, a0_pend, obs,
                     exp_vec());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL mid_write_run cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cen     = 1'($urandom_range(0, 1));
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_ch  = 3'($urandom_range(0, 7));
            cfg_div = 5'($urandom);
            cfg_ena = ($urandom_range(0, 5) != 0);
            sync    = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic write_all(input logic [4:0] d);
        for (int k = 0; k < 4; k++) begin
            cfg_we = 1; cfg_ch = 3'(k); cfg_div = d; cfg_ena = 1;
            @(negedge clk);
        end
        idle_inputs();
        sync = 1;
        @(negedge clk);
        sync = 0;
    endtask

    task automatic test_cascade();
        int n1 [4];
        int n0;
        cen = 1;
        write_all(5'd1);
        @(negedge clk);
        n1 = '{0, 0, 0, 0};
        n0 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) n1[k] += int'(a1_out[k]);
            n0 += int'(a0_out[3]);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL cascade cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (n1[0] != 16 || n1[1] != 8 || n1[2] != 4 || n1[3] != 2 || n0 != 16) begin
            fails++;
            $display("FAIL cascade_counts got %0d/%0d/%0d/%0d flat %0d want 16/8/4/2 flat 16",
                     n1[0], n1[1], n1[2], n1[3], n0);
        end
        cfg_we = 1; cfg_ch = 1; cfg_div = 1; cfg_ena = 0;
        @(negedge clk);
        idle_inputs();
        repeat (8) @(negedge clk);
        n0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n0 += int'(a1_out[3]) + int'(a1_out[2]) + int'(a1_out[1]);
            tests++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL starve cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
        tests++;
        if (n0 != 0) begin
            fails++;
            $display("FAIL starve_count got %0d want 0", n0);
        end
    endtask

    task automatic test_cen_toggle();
        logic last;
        cen = 0;
        write_all(5'd0);
        last = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (a0_out !== {4{last}} || obs !== exp_vec()) begin
                    fails++;
                    $display("FAIL cen_toggle cyc %0d got %h want %h", i, a0_out, {4{last}});
                end
            end
            last = 1'(i % 2);
            cen  = last;
        end
    endtask

    task automatic test_sync();
        cen = 1;
        write_all(5'd3);
        for (int i = 0; i < 6; i++) begin
            cen = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        cen = 0; sync = 1;
        @(negedge clk);
        sync = 0; cen = 1;
        @(negedge clk);
        cen = 0;
        tests++;
        if (a0_out !== 4'hF || a1_out !== 4'hF || obs !== exp_vec()) begin
            fails++;
            $display("FAIL sync_realign got %h/%h want f/f", a0_out, a1_out);
        end
    endtask

    task automatic test_bad_ch();
        cen = 0;
        @(negedge clk);
        cfg_we = 1; cfg_ch = 7; cfg_div = 5'd9; cfg_ena = 0;
        @(negedge clk);
        idle_inputs();
        tests++;
        if ({a0_ack, a0_err, a0_pend} !== 6'b110000 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL bad_ch got ack=%b err=%b pend=%h want ack=1 err=1 pend=0",
                     a0_ack, a0_err, a0_pend);
        end
    endtask

    task automatic test_wrap_write();
        int guard;
        int n;
        cen = 1;
        guard = 0;
        while (m_cnt[0][2] != m_da[0][2] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (guard >= 40) begin
            fails++;
            $display("FAIL wrap_wait got timeout want wrap within 40 cycles");
        end
        cfg_we = 1; cfg_ch = 2; cfg_div = 1; cfg_ena = 1;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (a0_pend[2] !== 1'b0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL wrap_write pend=%b got %h want pend=0 %h", a0_pend[2], obs, exp_vec());
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n += int'(a0_out[2]);
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL wrap_write_period got %0d want 4", n);
        end
    endtask

    initial begin
        rst = 1; cen = 0;
        idle_inputs();
        test_reset();
        test_startup();
        test_mid_write();
        test_random();
        test_cascade();
        test_cen_toggle();
        test_sync();
        test_bad_ch();
        test_wrap_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
